// File: rtl/ledstring_seq.sv
// LED string frame sequencer: walks a sine-indexed colour pattern along the string,
// handing one start transaction plus NUM_LEDS colour transactions per frame to doled.
module ledstring_seq #(
    parameter int unsigned NUM_LEDS    = 60,
    parameter int unsigned PHASE_STEP  = 3,
    parameter int unsigned PHASE_SPEED = 1,
    parameter int unsigned FRAME_GAP   = 1000
) (
    input  logic       clk,
    input  logic       ledstring_rst_n,
    input  logic       enable,
    input  logic       doledbusy,
    output logic [7:0] red,
    output logic [7:0] green,
    output logic [7:0] blue,
    output logic       ledstart,
    output logic       stringend,
    output logic       frame_done
);

    typedef enum logic [2:0] {IDLE, ISSUE, WAIT_ACK, WAIT_DONE, NEXT, GAP} state_t;

    localparam logic [9:0]  LAST_LED = 10'(NUM_LEDS);
    localparam logic [15:0] GAP_LAST = 16'(FRAME_GAP - 1);
    localparam logic [6:0]  STEP     = 7'(PHASE_STEP);
    localparam logic [6:0]  SPEED    = 7'(PHASE_SPEED);

    localparam logic [7:0] SINE_ROM [0:89] = '{
        8'd100, 8'd106, 8'd113, 8'd120, 8'd127, 8'd134, 8'd140, 8'd146, 8'd152, 8'd158,
        8'd164, 8'd169, 8'd174, 8'd178, 8'd182, 8'd186, 8'd189, 8'd192, 8'd195, 8'd197,
        8'd198, 8'd199, 8'd199, 8'd199, 8'd199, 8'd198, 8'd197, 8'd195, 8'd192, 8'd189,
        8'd186, 8'd182, 8'd178, 8'd174, 8'd169, 8'd164, 8'd158, 8'd152, 8'd146, 8'd140,
        8'd134, 8'd127, 8'd120, 8'd113, 8'd106, 8'd100, 8'd93,  8'd86,  8'd79,  8'd72,
        8'd65,  8'd59,  8'd53,  8'd47,  8'd41,  8'd35,  8'd30,  8'd25,  8'd21,  8'd17,
        8'd13,  8'd10,  8'd7,   8'd4,   8'd2,   8'd1,   8'd0,   8'd0,   8'd0,   8'd0,
        8'd1,   8'd2,   8'd4,   8'd7,   8'd10,  8'd13,  8'd17,  8'd21,  8'd25,  8'd30,
        8'd35,  8'd41,  8'd47,  8'd53,  8'd59,  8'd65,  8'd72,  8'd79,  8'd86,  8'd93
    };

    // Modulo-90 add; both operands are below 90 so a single subtract suffices.
    function automatic logic [6:0] idx_add(input logic [6:0] a, input logic [6:0] b);
        logic [7:0] s;
        s = {1'b0, a} + {1'b0, b};
        if (s >= 8'd90) s = s - 8'd90;
        return s[6:0];
    endfunction

    state_t      state, state_d;
    logic [6:0]  phase, phase_d, led_idx, led_idx_d;
    logic [9:0]  led_cnt, led_cnt_d;
    logic [15:0] gap_cnt, gap_cnt_d;
    logic [7:0]  red_d, green_d, blue_d;
    logic        ledstart_d, stringend_d, frame_done_d, start_frame;

    always_comb begin
        state_d      = state;
        phase_d      = phase;
        led_idx_d    = led_idx;
        led_cnt_d    = led_cnt;
        gap_cnt_d    = gap_cnt;
        red_d        = red;
        green_d      = green;
        blue_d       = blue;
        stringend_d  = stringend;
        ledstart_d   = 1'b0;
        frame_done_d = 1'b0;
        start_frame  = 1'b0;

        case (state)
            IDLE: begin
                if (enable && !doledbusy) start_frame = 1'b1;
            end
            ISSUE: begin
                ledstart_d = 1'b1;
                state_d    = WAIT_ACK;
            end
            WAIT_ACK: begin
                if (doledbusy) state_d = WAIT_DONE;
            end
            WAIT_DONE: begin
                if (!doledbusy) state_d = NEXT;
            end
            NEXT: begin
                if (led_cnt == LAST_LED) begin
                    frame_done_d = 1'b1;
                    phase_d      = idx_add(phase, SPEED);
                    gap_cnt_d    = '0;
                    state_d      = GAP;
                end else begin
                    red_d       = SINE_ROM[led_idx];
                    green_d     = SINE_ROM[idx_add(led_idx, 7'd30)];
                    blue_d      = SINE_ROM[idx_add(led_idx, 7'd60)];
                    stringend_d = 1'b0;
                    led_idx_d   = idx_add(led_idx, STEP);
                    led_cnt_d   = led_cnt + 10'd1;
                    state_d     = ISSUE;
                end
            end
            GAP: begin
                // Counter saturates at the end of the gap while a busy doled holds us off.
                if (gap_cnt != GAP_LAST)   gap_cnt_d = gap_cnt + 16'd1;
                else if (!enable)          state_d   = IDLE;
                else if (!doledbusy)       start_frame = 1'b1;
            end
            default: state_d = IDLE;
        endcase

        if (start_frame) begin
            state_d     = ISSUE;
            red_d       = '0;
            green_d     = '0;
            blue_d      = '0;
            stringend_d = 1'b1;
            led_cnt_d   = '0;
            led_idx_d   = phase;
        end
    end

    always_ff @(posedge clk or negedge ledstring_rst_n) begin
        if (!ledstring_rst_n) begin
            state      <= IDLE;
            phase      <= '0;
            led_idx    <= '0;
            led_cnt    <= '0;
            gap_cnt    <= '0;
            red        <= '0;
            green      <= '0;
            blue       <= '0;
            ledstart   <= 1'b0;
            stringend  <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            state      <= state_d;
            phase      <= phase_d;
            led_idx    <= led_idx_d;
            led_cnt    <= led_cnt_d;
            gap_cnt    <= gap_cnt_d;
            red        <= red_d;
            green      <= green_d;
            blue       <= blue_d;
            ledstart   <= ledstart_d;
            stringend  <= stringend_d;
            frame_done <= frame_done_d;
        end
    end

endmodule

// File: doc/ledstring_seq.md
LEDSTRING_SEQ -- requirements
Module: ledstring_seq

Interface
REQ-001 The block SHALL have parameter NUM_LEDS, default 60, giving the number of LEDs per frame, legal range 1..1023.
REQ-002 The block SHALL have parameter PHASE_STEP, default 3, giving the sine-index advance between adjacent LEDs, legal range 0..89.
REQ-003 The block SHALL have parameter PHASE_SPEED, default 1, giving the sine-index advance per frame, legal range 0..89.
REQ-004 The block SHALL have parameter FRAME_GAP, default 1000, giving the number of idle clocks between frames, legal range 1..65535.
REQ-005 Port clk SHALL be an input, 1 bit: the single clock; all logic is on its rising edge.
REQ-006 Port ledstring_rst_n SHALL be an input, 1 bit: reset, asynchronous, active-low.
REQ-007 Port enable SHALL be an input, 1 bit: run frames while high.
REQ-008 Port doledbusy SHALL be an input, 1 bit: busy flag from the downstream doled stage.
REQ-009 Port red SHALL be an output, 8 bits: red colour byte to doled.
REQ-010 Port green SHALL be an output, 8 bits: green colour byte to doled.
REQ-011 Port blue SHALL be an output, 8 bits: blue colour byte to doled.
REQ-012 Port ledstart SHALL be an output, 1 bit: one-cycle request to doled.
REQ-013 Port stringend SHALL be an output, 1 bit: marks a zero (start-frame) transaction.
REQ-014 Port frame_done SHALL be an output, 1 bit: one-cycle pulse at the end of each frame.
REQ-015 All outputs SHALL be registered.

Function
REQ-016 The block SHALL contain a 90-entry, 8-bit sine ROM equal to the team's sinewave table, with anchors sin[0]=100, sin[3]=120, sin[22]=199, sin[30]=186, sin[45]=100, sin[60]=13, sin[66]=0.
REQ-017 The FSM SHALL have exactly these states: IDLE, ISSUE, WAIT_ACK, WAIT_DONE, NEXT, GAP.
REQ-018 In IDLE with enable=1, the block SHALL go to ISSUE for the start transaction: stringend=1 and red/green/blue=0.
REQ-019 In ISSUE, the block SHALL drive ledstart=1 for exactly one cycle, then go to WAIT_ACK.
REQ-020 In WAIT_ACK, the block SHALL remain until doledbusy=1, then go to WAIT_DONE.
REQ-021 In WAIT_DONE, the block SHALL remain until doledbusy=0, then go to NEXT.
REQ-022 red, green, blue and stringend SHALL be held constant from the ISSUE cycle through the exit from WAIT_DONE.
REQ-023 In NEXT, the block SHALL load the next LED, with stringend=0, and go to ISSUE; after LED NUM_LEDS-1 it SHALL pulse frame_done and go to GAP instead.
REQ-024 LED i SHALL use index k = (phase + i*PHASE_STEP) mod 90, computed incrementally with add-then-subtract-90 on wrap; no multiplier or divider.
REQ-025 LED i SHALL output red=sin[k], green=sin[(k+30) mod 90] and blue=sin[(k+60) mod 90].
REQ-026 On each frame_done, phase SHALL update to (phase + PHASE_SPEED) mod 90.
REQ-027 GAP SHALL count FRAME_GAP clocks.
REQ-028 At the end of GAP, the block SHALL go to ISSUE (new start transaction) if enable=1, else to IDLE.
REQ-029 When enable falls mid-frame, the current frame SHALL complete, including frame_done; no partial frame is permitted.
REQ-030 If doledbusy=1 while in IDLE or GAP, the block SHALL NOT issue until doledbusy=0.
REQ-031 Latency: with enable sampled high in IDLE, ledstart SHALL assert on the 2nd rising edge.
REQ-032 Throughput: exactly one ledstart per doledbusy high-to-low cycle; never two ledstart pulses without an intervening doledbusy pulse.

Reset
REQ-033 When ledstring_rst_n=0, the block SHALL immediately force state=IDLE, phase=0, LED counter=0, gap counter=0, red=green=blue=0, ledstart=0, stringend=0, frame_done=0, regardless of state.
REQ-034 Reset asserted mid-transaction SHALL abort the transaction with no further ledstart.
REQ-035 After reset release, the first issue SHALL be a start transaction.

Verification
REQ-036 Scenario: NUM_LEDS=3, PHASE_STEP=3, doled model -> sequence (stringend=1; 0,0,0), (100,186,13), (120,174,4), (140,158,0 per table); then frame_done pulses once.
REQ-037 Scenario: wrap, with phase forced to 88 via PHASE_SPEED frames -> LED0 blue index 58 (21), LED1 red index 1 (106).
REQ-038 Scenario: doledbusy delayed 5 cycles after ledstart -> single ledstart; colours stable until busy falls.
REQ-039 Scenario: enable dropped at LED 1 of 3 -> LED 2 still sent, frame_done pulses, then IDLE with no new start.
REQ-040 Scenario: reset asserted in WAIT_DONE -> all outputs 0 asynchronously; after release with enable=1, first transaction has stringend=1.
REQ-041 Scenario: FRAME_GAP=4 -> exactly 4 clocks between frame_done and the next ledstart-qualified ISSUE.
